// File: rtl/bill_accumulator.sv
// bill_accumulator: sequential billing engine. Each accepted (item, qty) entry
// is priced from a parameter table, multiplied by a QTY_W-cycle shift-add
// multiplier, and added to a saturating total. The entry flagged last produces
// the discount/final amount behind a valid/ready output handshake.
module bill_accumulator #(
  parameter int unsigned NUM_ITEMS  = 5,
  parameter int unsigned PRICE_W    = 8,
  parameter int unsigned QTY_W      = 4,
  parameter int unsigned TOTAL_W    = 13,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES = {8'd120, 8'd150, 8'd100, 8'd25, 8'd50},
  parameter int unsigned LIMIT      = 1000,
  parameter int unsigned DISC_SHIFT = 2,
  localparam int unsigned IDW       = $clog2(NUM_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDW-1:0]     in_item,
  input  logic [QTY_W-1:0]   in_qty,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] total,
  output logic               ed,
  output logic [TOTAL_W-1:0] discount,
  output logic [TOTAL_W-1:0] final_amt,
  output logic               ovf,
  output logic               err
);

  localparam int unsigned PROD_W = PRICE_W + QTY_W;
  localparam int unsigned ACC_W  = TOTAL_W + 1;
  localparam int unsigned SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
  localparam int unsigned CNT_W  = $clog2(QTY_W + 1);
  localparam logic [TOTAL_W-1:0] MAX_TOTAL = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    ACC  = 3'd2,
    DISC = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [PRICE_W-1:0]  price_q;
  logic [QTY_W-1:0]    qsh_q;
  logic                last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PROD_W-1:0]   prod_q;
  logic [ACC_W-1:0]    acc_q;
  logic                ovf_q;
  logic                err_q;

  logic [PRICE_W-1:0]  price_c;
  logic                bad_item_c;
  logic [SUM_W-1:0]    sum_c;
  logic [TOTAL_W-1:0]  tot_c;
  logic [TOTAL_W-1:0]  disc_c;
  logic                ed_c;
  logic                accept_c;

  // Next-state logic plus price lookup and result arithmetic
  always_comb begin
    state_nxt  = state;
    price_c    = '0;
    bad_item_c = 1'b1;
    for (int k = 0; k < int'(NUM_ITEMS); k++) begin
      if (in_item == IDW'(k)) begin
        price_c    = PRICES[k*PRICE_W +: PRICE_W];
        bad_item_c = 1'b0;
      end
    end
    accept_c = in_valid && in_ready;
    sum_c    = SUM_W'(acc_q) + SUM_W'(prod_q);
    tot_c    = acc_q[TOTAL_W-1:0];
    ed_c     = (32'(acc_q) >= LIMIT);
    disc_c   = ed_c ? (tot_c >> DISC_SHIFT) : '0;
    unique case (state)
      IDLE: if (accept_c) state_nxt = MUL;
      MUL:  if (cnt_q == CNT_W'(QTY_W - 1)) state_nxt = ACC;
      ACC:  state_nxt = last_q ? DISC : IDLE;
      DISC: state_nxt = OUT;
      OUT:  if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath, sticky flags, handshake flags and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      price_q   <= '0;
      qsh_q     <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      total     <= '0;
      ed        <= 1'b0;
      discount  <= '0;
      final_amt <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == OUT);
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            price_q <= price_c;
            qsh_q   <= in_qty;
            last_q  <= in_last;
            prod_q  <= '0;
            cnt_q   <= '0;
            if (bad_item_c) err_q <= 1'b1;
          end
        end
        MUL: begin
          // MSB-first shift-add: one quantity bit per cycle
          prod_q <= PROD_W'({prod_q, 1'b0}) + (qsh_q[QTY_W-1] ? PROD_W'(price_q) : PROD_W'(0));
          qsh_q  <= qsh_q << 1;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        ACC: begin
          if (sum_c > SUM_W'(MAX_TOTAL)) begin
            acc_q <= ACC_W'(MAX_TOTAL);
            ovf_q <= 1'b1;
          end else begin
            acc_q <= ACC_W'(sum_c);
          end
        end
        DISC: begin
          total     <= tot_c;
          ed        <= ed_c;
          discount  <= disc_c;
          final_amt <= tot_c - disc_c;
          ovf       <= ovf_q;
          err       <= err_q;
        end
        OUT: begin
          if (out_ready) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
